// File: rtl/hdng_integrator.sv
// Yaw-rate heading integrator: averages 2^CAL_LOG2 samples to learn the gyro offset,
// then integrates offset-compensated, saturated yaw rate into a 24-bit wrapping heading.
module hdng_integrator #(
   parameter int CAL_LOG2 = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               strt_cal,
   input  logic               rate_vld,
   input  logic signed [15:0] yaw_rt,
   output logic               cal_done,
   output logic [11:0]        actl_hdng,
   output logic               hdng_vld,
   output logic [1:0]         dbg_state
);

   // Handshake: rate_vld is a one-cycle strobe with no back-pressure; every strobe
   // is consumed on the same rising edge, and hdng_vld/cal_done follow one clock later.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAL  = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam int ACC_W = 16 + CAL_LOG2;
   localparam int CNT_W = CAL_LOG2 + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << CAL_LOG2) - 1);

   state_t                    state_q, state_d;
   logic signed [ACC_W-1:0]   cal_acc_q, cal_acc_d;
   logic [CNT_W-1:0]          cal_cnt_q, cal_cnt_d;
   logic signed [15:0]        offset_q, offset_d;
   logic [23:0]               hdng_acc_q, hdng_acc_d;
   logic                      hdng_vld_q, hdng_vld_d;
   logic                      cal_done_q, cal_done_d;

   logic signed [ACC_W-1:0]   cal_sum;
   logic signed [16:0]        comp_wide;
   logic signed [15:0]        comp_sat;

   assign cal_sum   = cal_acc_q + {{CAL_LOG2{yaw_rt[15]}}, yaw_rt};
   assign comp_wide = {yaw_rt[15], yaw_rt} - {offset_q[15], offset_q};

   // A 17-bit difference leaves the 16-bit range exactly when its top two bits differ.
   always_comb begin
      comp_sat = comp_wide[15:0];
      if (comp_wide[16] != comp_wide[15]) begin
         comp_sat = comp_wide[16] ? 16'sh8000 : 16'sh7FFF;
      end
   end

   always_comb begin
      state_d    = state_q;
      cal_acc_d  = cal_acc_q;
      cal_cnt_d  = cal_cnt_q;
      offset_d   = offset_q;
      hdng_acc_d = hdng_acc_q;
      hdng_vld_d = 1'b0;
      cal_done_d = 1'b0;
      if (strt_cal) begin
         state_d    = CAL;
         cal_acc_d  = '0;
         cal_cnt_d  = '0;
         hdng_acc_d = '0;
      end else begin
         case (state_q)
            CAL: begin
               if (rate_vld) begin
                  cal_acc_d = cal_sum;
                  cal_cnt_d = cal_cnt_q + 1'b1;
                  if (cal_cnt_q == LAST_CNT) begin
                     // Taking the upper bits is the floor of the mean.
                     offset_d   = cal_sum[CAL_LOG2 +: 16];
                     state_d    = RUN;
                     cal_done_d = 1'b1;
                  end
               end
            end
            RUN: begin
               if (rate_vld) begin
                  hdng_acc_d = hdng_acc_q + {{8{comp_sat[15]}}, comp_sat};
                  hdng_vld_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cal_acc_q  <= '0;
         cal_cnt_q  <= '0;
         offset_q   <= '0;
         hdng_acc_q <= '0;
         hdng_vld_q <= 1'b0;
         cal_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cal_acc_q  <= cal_acc_d;
         cal_cnt_q  <= cal_cnt_d;
         offset_q   <= offset_d;
         hdng_acc_q <= hdng_acc_d;
         hdng_vld_q <= hdng_vld_d;
         cal_done_q <= cal_done_d;
      end
   end

   assign actl_hdng = hdng_acc_q[23:12];
   assign hdng_vld  = hdng_vld_q;
   assign cal_done  = cal_done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_hdng_integrator.sv
// Bench for hdng_integrator: directed vector table, async-reset sequence and
// random traffic, all checked against a sample-list/integer reference model.
module tb_hdng_integrator;

   localparam int CAL_LOG2 = 4;
   localparam int N_CAL    = 1 << CAL_LOG2;
   localparam int MOD24    = 1 << 24;

   logic               clk;
   logic               rst;
   logic               strt_cal;
   logic               rate_vld;
   logic signed [15:0] yaw_rt;
   logic               cal_done;
   logic [11:0]        actl_hdng;
   logic               hdng_vld;
   logic [1:0]         dbg_state;

   hdng_integrator #(.CAL_LOG2(CAL_LOG2)) dut (
      .clk       (clk),
      .rst       (rst),
      .strt_cal  (strt_cal),
      .rate_vld  (rate_vld),
      .yaw_rt    (yaw_rt),
      .cal_done  (cal_done),
      .actl_hdng (actl_hdng),
      .hdng_vld  (hdng_vld),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- counters ----------------
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Mode: 0 idle, 1 calibrating, 2 integrating. Heading kept as integer 0..2^24-1.
   int m_mode;
   int m_cal[$];
   int m_offset;
   int m_hdng;
   int e_vld;
   int e_done;

   function automatic int floor_div(input int num, input int den);
      int q;
      q = num / den;
      if ((num % den != 0) && (num < 0)) q = q - 1;
      return q;
   endfunction

   function automatic void model_reset();
      m_mode = 0;
      m_cal.delete();
      m_offset = 0;
      m_hdng = 0;
      e_vld = 0;
      e_done = 0;
   endfunction

   function automatic void model_step(input logic s, input logic v, input int y);
      int sum;
      int comp;
      e_vld = 0;
      e_done = 0;
      if (s) begin
         m_mode = 1;
         m_cal.delete();
         m_hdng = 0;
      end else if (m_mode == 1 && v) begin
         m_cal.push_back(y);
         if (m_cal.size() == N_CAL) begin
            sum = 0;
            foreach (m_cal[k]) sum += m_cal[k];
            m_offset = floor_div(sum, N_CAL);
            m_mode = 2;
            e_done = 1;
         end
      end else if (m_mode == 2 && v) begin
         comp = y - m_offset;
         if (comp > 32767) comp = 32767;
         if (comp < -32768) comp = -32768;
         m_hdng = ((m_hdng + comp) % MOD24 + MOD24) % MOD24;
         e_vld = 1;
      end
   endfunction

   // ---------------- driver ----------------
   task automatic step(input logic s, input logic v, input logic signed [15:0] y);
      int yi;
      yi = y;
      strt_cal = s;
      rate_vld = v;
      yaw_rt   = y;
      model_step(s, v, yi);
      @(posedge clk);
      #1;
      strt_cal = 1'b0;
      rate_vld = 1'b0;
      chk("model cal_done",  32'(cal_done),  32'(e_done));
      chk("model hdng_vld",  32'(hdng_vld),  32'(e_vld));
      chk("model actl_hdng", 32'(actl_hdng), 32'(m_hdng / 4096));
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic s;
      logic v;
      int   y;
      logic chk;
      int   e_hdng;
      logic e_vld;
      logic e_done;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic s, input logic v, input int y, input logic c,
                               input int eh, input logic ev, input logic ed);
      vec_t t;
      t.s = s; t.v = v; t.y = y; t.chk = c; t.e_hdng = eh; t.e_vld = ev; t.e_done = ed;
      vecs.push_back(t);
   endfunction

   function automatic void build_table();
      // offset 100, one step of 4096 counts
      add(1, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < N_CAL - 1; i++) add(0, 1, 100, 1, 0, 0, 0);
      add(0, 1, 100, 1, 0, 0, 1);
      add(0, 1, 4196, 1, 1, 1, 0);
      add(0, 0, 0, 1, 1, 0, 0);
      // negative mean floors to -4
      add(1, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < N_CAL; i++) add(0, 1, (i % 2 == 0) ? -3 : -4, (i == N_CAL - 1), 0, 0, (i == N_CAL - 1));
      add(0, 1, 4092, 1, 1, 1, 0);
      // saturation
      add(1, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < N_CAL; i++) add(0, 1, -100, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) add(0, 1, 32767, 0, 0, 0, 0);
      add(0, 1, 32767, 1, 63, 1, 0);
      // wrap both directions
      add(1, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < N_CAL; i++) add(0, 1, 0, 0, 0, 0, 0);
      add(0, 1, -4096, 1, 4095, 1, 0);
      add(0, 1, 4096, 1, 0, 1, 0);
      // strt_cal colliding with rate_vld in RUN, then recalibration
      add(0, 1, 8192, 1, 2, 1, 0);
      add(1, 1, 5000, 1, 0, 0, 0);
      for (int i = 0; i < N_CAL - 1; i++) add(0, 1, 7, 1, 0, 0, 0);
      add(0, 1, 7, 1, 0, 0, 1);
      add(0, 0, 0, 1, 0, 0, 0);
      // restart in the middle of calibration
      add(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) add(0, 1, 5, 0, 0, 0, 0);
      add(1, 1, 5, 1, 0, 0, 0);
      for (int i = 0; i < N_CAL - 1; i++) add(0, 1, 9, 0, 0, 0, 0);
      add(0, 1, 9, 1, 0, 0, 1);
      add(0, 1, 4105, 1, 1, 1, 0);
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic signed [15:0] ry;
      int r;
      rst = 1'b1;
      strt_cal = 1'b0;
      rate_vld = 1'b0;
      yaw_rt = '0;
      model_reset();
      build_table();
      #1;
      chk("reset actl_hdng", 32'(actl_hdng), 32'd0);
      chk("reset hdng_vld",  32'(hdng_vld),  32'd0);
      chk("reset cal_done",  32'(cal_done),  32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // idle: samples ignored
      step(0, 1, 16'sd1234);
      step(0, 1, 16'sd4096);

      foreach (vecs[i]) begin
         step(vecs[i].s, vecs[i].v, 16'(vecs[i].y));
         if (vecs[i].chk) begin
            chk("table actl_hdng", 32'(actl_hdng), 32'(vecs[i].e_hdng));
            chk("table hdng_vld",  32'(hdng_vld),  32'(vecs[i].e_vld));
            chk("table cal_done",  32'(cal_done),  32'(vecs[i].e_done));
         end
      end

      // asynchronous reset mid-RUN with heading 0x123
      step(1, 0, 16'sd0);
      for (int i = 0; i < N_CAL; i++) step(0, 1, 16'sd0);
      for (int i = 0; i < 36; i++) step(0, 1, 16'sd32767);
      step(0, 1, 16'sd12324);
      chk("pre-reset actl_hdng", 32'(actl_hdng), 32'h123);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("async rst actl_hdng", 32'(actl_hdng), 32'd0);
      chk("async rst hdng_vld",  32'(hdng_vld),  32'd0);
      chk("async rst cal_done",  32'(cal_done),  32'd0);
      #2;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step(0, 1, 16'sd1000);

      // random traffic
      step(1, 0, 16'sd0);
      for (int i = 0; i < 800; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0: ry = 16'sh7FFF;
            1: ry = 16'sh8000;
            2, 3, 4: ry = 16'($urandom_range(0, 400)) - 16'sd200;
            default: ry = 16'($urandom);
         endcase
         step($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0, ry);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
